// File: rtl/tetris_game_ctrl_if.sv
// Button pulses, shape-ROM lookup and piece/board state exchanged with the game sequencer.
interface tetris_game_ctrl_if #(
    parameter int COLS = 10,
    parameter int ROWS = 20
);
    logic                   i_pls_e;
    logic                   i_pls_w;
    logic                   i_pls_s;
    logic                   i_pls_n;
    logic                   i_pls_c;
    logic [2:0]             i_rand_id;
    logic [3:0]             o_shp_id;
    logic [1:0]             o_shp_rad;
    logic [15:0]            i_shp_mask;
    logic [9:0]             o_blk_pos_x;
    logic [9:0]             o_blk_pos_y;
    logic [3:0]             o_blk_id;
    logic [1:0]             o_blk_rad;
    logic [COLS*ROWS-1:0]   o_board;
    logic [15:0]            o_lines;
    logic                   o_game_over;
    logic                   o_busy;

    modport slave (
        input  i_pls_e, i_pls_w, i_pls_s, i_pls_n, i_pls_c, i_rand_id, i_shp_mask,
        output o_shp_id, o_shp_rad, o_blk_pos_x, o_blk_pos_y, o_blk_id, o_blk_rad,
               o_board, o_lines, o_game_over, o_busy
    );

    modport master (
        output i_pls_e, i_pls_w, i_pls_s, i_pls_n, i_pls_c, i_rand_id, i_shp_mask,
        input  o_shp_id, o_shp_rad, o_blk_pos_x, o_blk_pos_y, o_blk_id, o_blk_rad,
               o_board, o_lines, o_game_over, o_busy
    );
endinterface

// File: rtl/tetris_game_ctrl.sv
// Tetris sequencer: serialises pulses/gravity into moves, checks collisions, locks, clears rows, spawns.
// Latency: pulse to o_blk_* in 3 edges from IDLE; no backpressure, repeat pulses merge into pending flags.
module tetris_game_ctrl #(
    parameter int COLS        = 10,
    parameter int ROWS        = 20,
    parameter int GRAVITY_DIV = 25000000,
    parameter int SPAWN_X     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    tetris_game_ctrl_if.slave bus
);
    localparam int BW  = COLS * ROWS;
    localparam int BIW = (BW > 1) ? $clog2(BW) : 1;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GW  = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHECK     = 3'd1;
    localparam logic [2:0] LOCK      = 3'd2;
    localparam logic [2:0] SCAN      = 3'd3;
    localparam logic [2:0] SHIFT     = 3'd4;
    localparam logic [2:0] SPAWN     = 3'd5;
    localparam logic [2:0] SPAWN_CHK = 3'd6;
    localparam logic [2:0] GAME_OVER = 3'd7;

    // flag bit order doubles as selection priority
    localparam int F_DOWN = 3;
    localparam int F_ROT  = 2;
    localparam int F_EAST = 1;
    localparam int F_WEST = 0;

    logic [2:0]          state;
    logic [9:0]          pos_x;
    logic [9:0]          pos_y;
    logic [3:0]          id;
    logic [1:0]          rad;
    logic [BW-1:0]       board;
    logic [15:0]         lines;
    logic [3:0]          flags;
    logic [GW-1:0]       grav_cnt;
    logic signed [10:0]  cand_x;
    logic [9:0]          cand_y;
    logic [1:0]          cand_rad;
    logic                cand_down;
    logic [RW-1:0]       row;

    logic                grav_wrap;
    logic [3:0]          set_flags;
    logic [3:0]          sel;
    logic                hit;
    logic [BW-1:0]       lock_cells;
    logic [BIW-1:0]      idx;
    int                  tst_x;
    int                  tst_y;
    logic [BW-1:0]       keep_m;
    logic [BW-1:0]       low_m;
    logic [BW-1:0]       shifted;
    logic [COLS-1:0]     row_bits;
    logic                row_full;

    assign grav_wrap = (grav_cnt == GW'(GRAVITY_DIV - 1));
    assign set_flags = {bus.i_pls_s | grav_wrap, bus.i_pls_n, bus.i_pls_e, bus.i_pls_w};

    always_comb begin
        sel = 4'b0000;
        if (state == IDLE) begin
            if (flags[F_DOWN])      sel = 4'b1000;
            else if (flags[F_ROT])  sel = 4'b0100;
            else if (flags[F_EAST]) sel = 4'b0010;
            else if (flags[F_WEST]) sel = 4'b0001;
        end
    end

    // CHECK tests the candidate; every other state tests the piece as it stands
    always_comb begin
        hit        = 1'b0;
        lock_cells = '0;
        idx        = '0;
        tst_x      = (state == CHECK) ? int'(cand_x) : int'(pos_x);
        tst_y      = (state == CHECK) ? int'(cand_y) : int'(pos_y);
        for (int i = 0; i < 16; i++) begin
            if (bus.i_shp_mask[i]) begin
                if ((tst_x + i % 4 < 0) || (tst_x + i % 4 >= COLS) || (tst_y + i / 4 >= ROWS)) begin
                    hit = 1'b1;
                end else begin
                    idx = BIW'((tst_y + i / 4) * COLS + tst_x + i % 4);
                    if (board[idx]) hit = 1'b1;
                    lock_cells[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        keep_m   = {BW{1'b1}} << ((int'(row) + 1) * COLS);
        low_m    = ~({BW{1'b1}} << (int'(row) * COLS));
        shifted  = (board & keep_m) | ((board & low_m) << COLS);
        row_bits = COLS'(board >> (int'(row) * COLS));
        row_full = &row_bits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pos_x     <= 10'(SPAWN_X);
            pos_y     <= '0;
            id        <= '0;
            rad       <= '0;
            board     <= '0;
            lines     <= '0;
            flags     <= '0;
            grav_cnt  <= '0;
            cand_x    <= '0;
            cand_y    <= '0;
            cand_rad  <= '0;
            cand_down <= 1'b0;
            row       <= '0;
        end else begin
            if (state == SPAWN)
                grav_cnt <= '0;
            else if (state != GAME_OVER)
                grav_cnt <= grav_wrap ? '0 : grav_cnt + 1'b1;

            if (state == SPAWN)
                flags <= '0;
            else if (state != GAME_OVER)
                flags <= (flags & ~sel) | set_flags;

            case (state)
                IDLE: begin
                    if (|flags) begin
                        cand_x    <= $signed({1'b0, pos_x});
                        cand_y    <= pos_y;
                        cand_rad  <= rad;
                        cand_down <= sel[F_DOWN];
                        if (sel[F_DOWN]) cand_y   <= pos_y + 1'b1;
                        if (sel[F_ROT])  cand_rad <= rad + 1'b1;
                        if (sel[F_EAST]) cand_x   <= $signed({1'b0, pos_x}) + 11'sd1;
                        if (sel[F_WEST]) cand_x   <= $signed({1'b0, pos_x}) - 11'sd1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!hit) begin
                        pos_x <= cand_x[9:0];
                        pos_y <= cand_y;
                        rad   <= cand_rad;
                        state <= IDLE;
                    end else begin
                        state <= cand_down ? LOCK : IDLE;
                    end
                end
                LOCK: begin
                    board <= board | lock_cells;
                    row   <= RW'(ROWS - 1);
                    state <= SCAN;
                end
                SCAN: begin
                    if (row_full)
                        state <= SHIFT;
                    else if (row == '0)
                        state <= SPAWN;
                    else
                        row <= row - 1'b1;
                end
                SHIFT: begin
                    board <= shifted;
                    if (lines != 16'hFFFF) lines <= lines + 1'b1;
                    state <= SCAN;
                end
                SPAWN: begin
                    id    <= (bus.i_rand_id == 3'd7) ? 4'd0 : {1'b0, bus.i_rand_id};
                    rad   <= '0;
                    pos_x <= 10'(SPAWN_X);
                    pos_y <= '0;
                    state <= SPAWN_CHK;
                end
                SPAWN_CHK: begin
                    state <= hit ? GAME_OVER : IDLE;
                end
                GAME_OVER: begin
                    if (bus.i_pls_c) begin
                        board <= '0;
                        lines <= '0;
                        state <= SPAWN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_shp_id    = id;
    assign bus.o_shp_rad   = (state == CHECK) ? cand_rad : rad;
    assign bus.o_blk_pos_x = pos_x;
    assign bus.o_blk_pos_y = pos_y;
    assign bus.o_blk_id    = id;
    assign bus.o_blk_rad   = rad;
    assign bus.o_board     = board;
    assign bus.o_lines     = lines;
    assign bus.o_game_over = (state == GAME_OVER);
    assign bus.o_busy      = (state != IDLE) && (state != GAME_OVER);
endmodule
